// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: Y86-64 memory stage with word-organised data memory,
// optional multi-cycle latency (m_busy stall request) and the W register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   M_icode/M_stat        instruction code and status from the M register
//   M_valA/M_valE         operand and computed address/value from E
//   M_dstE/M_dstM         destination register IDs
//   W_stall/W_bubble      W register control from the hazard unit
//   m_valM/m_stat/m_busy  combinational read data, status, stall request
//   W_*                   W pipeline register fields
module pipe_mem_stage #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        M_icode,
  input  logic [2:0]        M_stat,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [DATA_W-1:0] m_valM,
  output logic [2:0]        m_stat,
  output logic              m_busy,
  output logic [3:0]        W_icode,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM
);

  localparam int B  = DATA_W / 8;
  localparam int LB = $clog2(B);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam int LM = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [2:0] S_ADR   = 3'd3;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [3:0]        icode;
    logic [2:0]        stat;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
  } w_t;

  localparam w_t W_BUB = '{
    icode: I_NOP, stat: S_AOK,
    dstE: 4'hF, dstM: 4'hF,
    valE: '0, valM: '0
  };

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              is_rd;
  logic              is_wr;
  logic              mem_op;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] word;
  logic [IW-1:0]     idx;
  logic              ok;
  logic              eff;
  logic              done;
  logic              busy;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  w_t                w_q;

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    unique case (M_icode)
      I_MRMOV, I_RET, I_POP:  is_rd = 1'b1;
      I_RMMOV, I_CALL, I_PUSH: is_wr = 1'b1;
      default: ;
    endcase
  end

  assign mem_op = is_rd | is_wr;
  assign addr   = (M_icode == I_MRMOV || is_wr) ?
                  M_valE : M_valA;
  assign word   = addr >> LB;
  assign idx    = word[IW-1:0];
  assign ok     = (addr[LB-1:0] == '0) &&
                  (word < DATA_W'(DEPTH));
  assign eff    = mem_op && (M_stat == S_AOK) && ok;

  assign m_stat = (M_stat != S_AOK) ? M_stat :
                  (mem_op && !ok)   ? S_ADR  : S_AOK;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (eff) begin
          if (MEM_LAT == 0) begin
            done = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CW'(LM);
            busy    = 1'b1;
          end
        end
      end
      (state == WAIT): begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
          busy  = 1'b1;
        end else begin
          done    = eff;
          state_n = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Memory has no reset; a write under reset is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && done && is_wr)
      mem[idx] <= M_valA;
  end

  assign m_valM = (done && is_rd) ? mem[idx] : '0;
  assign m_busy = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      w_q <= W_BUB;
    else if (W_stall)
      w_q <= w_q;
    else if (W_bubble || busy)
      w_q <= W_BUB;
    else
      w_q <= '{
        icode: M_icode, stat: m_stat,
        dstE: M_dstE, dstM: M_dstM,
        valE: M_valE, valM: m_valM
      };
  end

  assign W_icode = w_q.icode;
  assign W_stat  = w_q.stat;
  assign W_dstE  = w_q.dstE;
  assign W_dstM  = w_q.dstM;
  assign W_valE  = w_q.valE;
  assign W_valM  = w_q.valM;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: checks pipe_mem_stage at MEM_LAT 0, 2 and 3
// against a word-array memory model and the stage's status/W rules.
module tb_pipe_mem_stage;

  logic clk;
  logic rst_n;

  logic [3:0]  icode [3];
  logic [2:0]  stat  [3];
  logic [63:0] valA  [3];
  logic [63:0] valE  [3];
  logic [3:0]  dstE  [3];
  logic [3:0]  dstM  [3];
  logic        wst   [3];
  logic        wbb   [3];

  logic [63:0] valM  [3];
  logic [2:0]  mstat [3];
  logic        busy  [3];
  logic [3:0]  Wic   [3];
  logic [2:0]  Wst   [3];
  logic [3:0]  WdE   [3];
  logic [3:0]  WdM   [3];
  logic [63:0] WvE   [3];
  logic [63:0] WvM   [3];

  int LAT [3] = '{0, 2, 3};

  for (genvar g = 0; g < 3; g++) begin : u
    pipe_mem_stage #(
      .DATA_W(64), .DEPTH(64),
      .MEM_LAT((g == 0) ? 0 : g + 1)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .M_icode(icode[g]), .M_stat(stat[g]),
      .M_valA(valA[g]), .M_valE(valE[g]),
      .M_dstE(dstE[g]), .M_dstM(dstM[g]),
      .W_stall(wst[g]), .W_bubble(wbb[g]),
      .m_valM(valM[g]), .m_stat(mstat[g]),
      .m_busy(busy[g]),
      .W_icode(Wic[g]), .W_stat(Wst[g]),
      .W_dstE(WdE[g]), .W_dstM(WdM[g]),
      .W_valE(WvE[g]), .W_valM(WvM[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] mdl [3][64];

  logic [3:0]  ew_ic [3];
  logic [2:0]  ew_st [3];
  logic [3:0]  ew_de [3];
  logic [3:0]  ew_dm [3];
  logic [63:0] ew_ve [3];
  logic [63:0] ew_vm [3];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(input int k, input string tag);
    chk({tag, "_ic"}, 64'(Wic[k]), 64'h1);
    chk({tag, "_st"}, 64'(Wst[k]), 64'h1);
    chk({tag, "_de"}, 64'(WdE[k]), 64'hF);
    chk({tag, "_dm"}, 64'(WdM[k]), 64'hF);
    chk({tag, "_ve"}, WvE[k], 64'h0);
    chk({tag, "_vm"}, WvM[k], 64'h0);
  endtask

  task automatic chk_w(input int k, input string tag);
    chk({tag, "_ic"}, 64'(Wic[k]), 64'(ew_ic[k]));
    chk({tag, "_st"}, 64'(Wst[k]), 64'(ew_st[k]));
    chk({tag, "_de"}, 64'(WdE[k]), 64'(ew_de[k]));
    chk({tag, "_dm"}, 64'(WdM[k]), 64'(ew_dm[k]));
    chk({tag, "_ve"}, WvE[k], ew_ve[k]);
    chk({tag, "_vm"}, WvM[k], ew_vm[k]);
  endtask

  task automatic park(input int k);
    icode[k] = 4'h1; stat[k] = 3'd1;
    valA[k] = '0; valE[k] = '0;
    dstE[k] = 4'hF; dstM[k] = 4'hF;
    wst[k] = 1'b0; wbb[k] = 1'b0;
  endtask

  // Called just after a falling edge; returns just after one.
  task automatic do_op(input int k, input logic [3:0] ic,
                       input logic [2:0] st,
                       input logic [63:0] a, input logic [63:0] e,
                       input logic [3:0] de, input logic [3:0] dm);
    logic rd, wr, ok, eff;
    logic [63:0] ad, ev;
    logic [2:0] es;
    int n;
    icode[k] = ic; stat[k] = st;
    valA[k] = a; valE[k] = e;
    dstE[k] = de; dstM[k] = dm;
    wst[k] = 1'b0; wbb[k] = 1'b0;
    rd  = ic inside {4'h5, 4'h9, 4'hB};
    wr  = ic inside {4'h4, 4'h8, 4'hA};
    ad  = (ic == 4'h5 || wr) ? e : a;
    ok  = (ad % 8 == 0) && (ad / 8 < 64);
    eff = (rd || wr) && st == 3'd1 && ok;
    es  = (st != 3'd1) ? st :
          ((rd || wr) && !ok) ? 3'd3 : 3'd1;
    ev  = (eff && rd) ? mdl[k][ad[8:3]] : 64'h0;
    n   = eff ? LAT[k] : 0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("busy_hi", 64'(busy[k]), 64'h1);
      @(posedge clk); #1;
      chk("busy_bub", 64'(Wic[k]), 64'h1);
      @(negedge clk);
    end
    #1;
    chk("busy_lo", 64'(busy[k]), 64'h0);
    chk("m_stat", 64'(mstat[k]), 64'(es));
    chk("m_valM", valM[k], ev);
    ew_ic[k] = ic; ew_st[k] = es;
    ew_de[k] = de; ew_dm[k] = dm;
    ew_ve[k] = e;  ew_vm[k] = ev;
    @(posedge clk); #1;
    chk_w(k, "wload");
    if (eff && wr) mdl[k][ad[8:3]] = a;
    @(negedge clk);
    park(k);
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] r;
    r = 64'($urandom_range(0, 63)) << 3;
    case ($urandom_range(0, 3))
      0, 1: ;
      2: r = r + 64'($urandom_range(1, 7));
      default: r = r + 64'd512;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ic;
    logic [2:0]  st;
    logic [63:0] a, e;
    for (int k = 0; k < 3; k++) begin
      park(k);
      for (int j = 0; j < 64; j++) mdl[k][j] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 64'(busy[k]), 64'h0);
      chk_bubble(k, "rst");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle write then read
    do_op(0, 4'h4, 3'd1, 64'hDEAD, 64'h20, 4'hF, 4'hF);
    do_op(0, 4'h5, 3'd1, 64'h0, 64'h20, 4'hF, 4'h3);
    chk("t1_wvm", WvM[0], 64'hDEAD);

    // Latency 2 read of preloaded word
    do_op(1, 4'h4, 3'd1, 64'd55, 64'h18, 4'hF, 4'hF);
    do_op(1, 4'h5, 3'd1, 64'h0, 64'h18, 4'hF, 4'h2);
    chk("t2_wvm", WvM[1], 64'd55);

    // Stack address selection
    do_op(0, 4'hA, 3'd1, 64'd7, 64'h100, 4'h4, 4'hF);
    do_op(0, 4'hB, 3'd1, 64'h100, 64'h108, 4'h4, 4'h1);
    chk("pop_wvm", WvM[0], 64'd7);
    do_op(0, 4'h8, 3'd1, 64'h1234, 64'h80, 4'h4, 4'hF);
    do_op(0, 4'h9, 3'd1, 64'h80, 64'h88, 4'h4, 4'hF);
    chk("ret_wvm", WvM[0], 64'h1234);

    // Address and status faults
    do_op(0, 4'h4, 3'd1, 64'hBAD, 64'h21, 4'hF, 4'hF);
    chk("mis_wst", 64'(Wst[0]), 64'h3);
    do_op(0, 4'h5, 3'd1, 64'h0, 64'h20, 4'hF, 4'h3);
    chk("mis_old", WvM[0], 64'hDEAD);
    do_op(0, 4'h5, 3'd1, 64'h0, 64'd512, 4'hF, 4'h3);
    chk("oor_wst", 64'(Wst[0]), 64'h3);
    do_op(0, 4'h4, 3'd2, 64'hBEEF, 64'h20, 4'hF, 4'hF);
    chk("hlt_wst", 64'(Wst[0]), 64'h2);
    do_op(0, 4'h5, 3'd1, 64'h0, 64'h20, 4'hF, 4'h3);
    chk("hlt_old", WvM[0], 64'hDEAD);

    // W_stall holds, W_bubble clears
    wst[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      icode[0] = (i == 1) ? 4'h5 : 4'h6;
      valE[0] = 64'($urandom_range(0, 63)) << 3;
      valA[0] = {$urandom, $urandom};
      dstE[0] = 4'($urandom_range(0, 14));
      @(posedge clk); #1;
      chk_w(0, "stall");
      @(negedge clk);
    end
    park(0);
    wbb[0] = 1'b1;
    icode[0] = 4'h6;
    dstE[0] = 4'h2;
    @(posedge clk); #1;
    chk_bubble(0, "wbub");
    @(negedge clk);
    park(0);

    // Reset in 2nd busy cycle, op abandoned
    icode[2] = 4'hA; valE[2] = 64'h40;
    valA[2] = 64'h77; dstE[2] = 4'h4;
    #1;
    chk("r_busy1", 64'(busy[2]), 64'h1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_bubble(2, "rstA");
    park(2);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2, 4'h5, 3'd1, 64'h0, 64'h40, 4'hF, 4'h3);
    chk("rstA_keep", WvM[2], 64'h0);

    // Reset in 2nd busy cycle, op held and restarted
    icode[2] = 4'hA; valE[2] = 64'h40;
    valA[2] = 64'h77; dstE[2] = 4'h4;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_bubble(2, "rstB");
    chk("rstB_busy", 64'(busy[2]), 64'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2, 4'hA, 3'd1, 64'h77, 64'h40, 4'h4, 4'hF);
    do_op(2, 4'h5, 3'd1, 64'h0, 64'h40, 4'hF, 4'h3);
    chk("rstB_val", WvM[2], 64'h77);

    // Randomised ops against the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        ic = 4'($urandom_range(0, 11));
        st = ($urandom_range(0, 7) < 6) ? 3'd1 :
             3'($urandom_range(2, 4));
        e  = rnd_addr();
        a  = $urandom_range(0, 1) ? rnd_addr() :
             {$urandom, $urandom};
        do_op(k, ic, st, a, e,
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
